// File: rtl/fp32_pkg.sv
// fp32_pkg: shared constants, class encodings, FSM states and classifier for the fp32 library
package fp32_pkg;
    localparam logic [31:0] QNAN     = 32'h7FC00001;
    localparam int          EXP_BIAS = 127;
    localparam int          EXP_W    = 8;
    localparam int          MANT_W   = 23;
    localparam int          ITER     = 26;

    typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORM} cls_t;
    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    // Denormals have a zero exponent field and therefore classify as zero (flush-to-zero).
    function automatic cls_t classify(input logic [31:0] x);
        return (x[30:MANT_W] == '1) ? ((x[MANT_W-1:0] != '0) ? CLS_NAN : CLS_INF) :
               (x[30:MANT_W] == '0) ? CLS_ZERO : CLS_NORM;
    endfunction
endpackage

// File: rtl/fp32_mant_div.sv
// fp32_mant_div: iterative restoring divider producing a 26-bit mantissa quotient
// Ports: clk, rst_n (async, active-low); start loads ma/mb; q = quotient (1 integer +
// 25 fraction bits), sticky = nonzero remainder, done = high during the final iteration.
module fp32_mant_div
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [23:0]       ma,
    input  logic [23:0]       mb,
    output logic [ITER-1:0]   q,
    output logic              sticky,
    output logic              done
);
    logic [25:0] r;
    logic [25:0] r_sub;
    logic [23:0] d;
    logic [4:0]  cnt;
    logic        busy;
    logic        ge;

    assign ge     = r >= {2'b00, d};
    assign r_sub  = ge ? r - {2'b00, d} : r;
    assign sticky = r != '0;
    assign done   = busy && cnt == 5'(ITER - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            d    <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            r    <= {2'b00, ma};
            d    <= mb;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            q    <= {q[ITER-2:0], ge};
            r    <= r_sub << 1;
            cnt  <= cnt + 5'd1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/fp32_div_seq.sv
// fp32_div_seq: sequential fp32 divider a / b with RNE rounding and valid/ready handshake
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with operands a, b;
// out_valid/out_ready with quotient result and flags {NV, DZ, OF, UF, NX}.
module fp32_div_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  flags
);
    state_t             state, state_nx;
    cls_t               ca, cb;
    logic               accept, special, s_in, sign;
    logic [31:0]        sp_res, nm_res;
    logic [4:0]         sp_flg, nm_flg;
    logic [EXP_W-1:0]   ea, eb;
    logic [ITER-1:0]    q;
    logic               sticky, done;
    logic               hi, guard, st, inc, nx;
    logic [MANT_W-1:0]  mant;
    logic [MANT_W:0]    mant_r;
    logic signed [9:0]  exp_n, exp_r;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign ca        = classify(a);
    assign cb        = classify(b);
    assign s_in      = a[31] ^ b[31];

    // Operand pairs that never need the mantissa divider resolve straight to DONE.
    always_comb begin
        sp_res  = {s_in, 31'd0};
        sp_flg  = 5'b00000;
        special = 1'b1;
        if (ca == CLS_NAN || cb == CLS_NAN)
            sp_res = QNAN;
        else if ((ca == CLS_ZERO && cb == CLS_ZERO) || (ca == CLS_INF && cb == CLS_INF)) begin
            sp_res = QNAN;
            sp_flg = 5'b10000;
        end else if (ca == CLS_INF)
            sp_res = {s_in, 8'hFF, 23'd0};
        else if (cb == CLS_ZERO) begin
            sp_res = {s_in, 8'hFF, 23'd0};
            sp_flg = 5'b01000;
        end else if (cb != CLS_INF && ca != CLS_ZERO)
            special = 1'b0;
    end

    fp32_mant_div u_mant_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && !special),
        .ma     ({1'b1, a[MANT_W-1:0]}),
        .mb     ({1'b1, b[MANT_W-1:0]}),
        .q      (q),
        .sticky (sticky),
        .done   (done)
    );

    // A quotient below 1.0 has its leading one at q[24], costing one exponent step.
    always_comb begin
        hi     = q[ITER-1];
        mant   = hi ? q[24:2] : q[23:1];
        guard  = hi ? q[1] : q[0];
        st     = hi ? (q[0] | sticky) : sticky;
        exp_n  = $signed({2'b00, ea}) - $signed({2'b00, eb})
               + (hi ? $signed(10'(EXP_BIAS)) : $signed(10'(EXP_BIAS - 1)));
        inc    = guard & (st | mant[0]);
        mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
        exp_r  = exp_n + $signed({9'd0, mant_r[MANT_W]});
        nx     = guard | st;
        nm_res = (exp_r >= 10'sd255) ? {sign, 8'hFF, 23'd0} :
                 (exp_r <= 10'sd0)   ? {sign, 31'd0} : {sign, exp_r[7:0], mant_r[MANT_W-1:0]};
        nm_flg = (exp_r >= 10'sd255) ? 5'b00101 :
                 (exp_r <= 10'sd0)   ? 5'b00011 : {4'b0000, nx};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = accept ? (special ? DONE : CALC) : IDLE;
            CALC: state_nx = done ? NORM : CALC;
            NORM: state_nx = DONE;
            DONE: state_nx = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign   <= 1'b0;
            ea     <= '0;
            eb     <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            if (accept) begin
                sign <= s_in;
                ea   <= a[30:MANT_W];
                eb   <= b[30:MANT_W];
            end
            if (accept && special) begin
                result <= sp_res;
                flags  <= sp_flg;
            end else if (state == NORM) begin
                result <= nm_res;
                flags  <= nm_flg;
            end
        end
    end
endmodule

// File: tb/tb_fp32_div_seq.sv
// tb_fp32_div_seq: directed-vector bench with a behavioural quotient model and per-cycle output checks
module tb_fp32_div_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid;
    logic [31:0] result;
    logic [4:0]  flags;

    fp32_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [37:0] exp_q[$];
    int          acc_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          seen = 1'b0;

    // Expected outcome {special, flags, result}, derived from the real-valued quotient
    // computed with wide integer division and rounded to nearest-even.
    function automatic logic [37:0] model(input logic [31:0] x, input logic [31:0] y);
        logic s = x[31] ^ y[31];
        int ex = int'(x[30:23]);
        int ey = int'(y[30:23]);
        bit zx = ex == 0;
        bit zy = ey == 0;
        bit ix = ex == 255 && x[22:0] == 0;
        bit iy = ey == 255 && y[22:0] == 0;
        bit nan = (ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0);
        longint unsigned ma, mb, qt, rm, kept, low, half;
        int e, sh;
        bit up, inx;
        if (nan) return {1'b1, 5'h00, 32'h7FC00001};
        if ((zx && zy) || (ix && iy)) return {1'b1, 5'h10, 32'h7FC00001};
        if (ix) return {1'b1, 5'h00, s, 8'hFF, 23'h0};
        if (zy) return {1'b1, 5'h08, s, 8'hFF, 23'h0};
        if (iy || zx) return {1'b1, 5'h00, s, 31'h0};
        ma   = 64'h800000 | 64'(x[22:0]);
        mb   = 64'h800000 | 64'(y[22:0]);
        qt   = (ma << 26) / mb;
        rm   = (ma << 26) % mb;
        sh   = (qt >= (64'd1 << 26)) ? 3 : 2;
        e    = ex - ey + 124 + sh;
        kept = qt >> sh;
        low  = qt & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        up   = low > half || (low == half && (rm != 0 || kept[0]));
        inx  = low != 0 || rm != 0;
        kept = kept + 64'(up);
        if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            e++;
        end
        if (e >= 255) return {1'b0, 5'h05, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, 5'h03, s, 31'h0};
        return {1'b0, 4'h0, inx, s, 8'(e), kept[22:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0)
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                else begin
                    chk("result", result, exp_q[0][31:0]);
                    chk("flags", 32'(flags), 32'(exp_q[0][36:32]));
                    chk("in_ready_while_done", 32'(in_ready), 32'd0);
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 32'(cyc - acc_q[0] + 1), exp_q[0][37] ? 32'd1 : 32'd28);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    endtask

    // Called one step after a rising edge; returns one step after the accept edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(model(x, y));
        acc_q.push_back(cyc);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    localparam int NV = 17;
    logic [31:0] va [NV] = '{32'h3F800000, 32'h40C00000, 32'h3F800000, 32'h00000000, 32'hFF800000,
                             32'h7F7FFFFF, 32'h00800000, 32'h7FC00000, 32'h40000000, 32'h80000000,
                             32'hC0E00000, 32'h3F800000, 32'h00400000, 32'h3F800000, 32'h7F800000,
                             32'h3F800000, 32'h41200000};
    logic [31:0] vb [NV] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000, 32'h40000000,
                             32'h3F000000, 32'h40000000, 32'h3F800000, 32'h7F800000, 32'h40000000,
                             32'h40000000, 32'h40E00000, 32'h3F800000, 32'h00400000, 32'h7F800000,
                             32'hFF800000, 32'h40400000};
    logic [31:0] vr [NV] = '{32'h3EAAAAAB, 32'h40400000, 32'h7F800000, 32'h7FC00001, 32'hFF800000,
                             32'h7F800000, 32'h00000000, 32'h7FC00001, 32'h00000000, 32'h80000000,
                             32'hC0600000, 32'h3E124925, 32'h00000000, 32'h7F800000, 32'h7FC00001,
                             32'h80000000, 32'h40555555};
    logic [4:0]  vf [NV] = '{5'h01, 5'h00, 5'h08, 5'h10, 5'h00,
                             5'h05, 5'h03, 5'h00, 5'h00, 5'h00,
                             5'h00, 5'h01, 5'h00, 5'h08, 5'h10,
                             5'h00, 5'h01};

    task automatic stimulus();
        logic [37:0] m;
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            m = model(va[i], vb[i]);
            chk($sformatf("model_result_%0d", i), m[31:0], vr[i]);
            chk($sformatf("model_flags_%0d", i), 32'(m[36:32]), 32'(vf[i]));
        end
        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i]);
            drain();
        end
        // Backpressure: hold the result for 10 cycles and pulse in_valid while busy.
        out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 32'h3F800000;
                b = 32'h40400000;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        drain();
        issue(32'h3F800000, 32'h40400000);
        drain();
        // Asynchronous reset in the middle of a division.
        issue(32'h40C00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_result", result, 32'd0);
        exp_q.delete();
        acc_q.delete();
        seen = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h40C00000, 32'h40000000);
        drain();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
    end
endmodule

// File: doc/fp32_div_seq.md
# fp32_div_seq

Sequential single-precision floating-point divider computing a / b, with a valid/ready handshake on the operand and result sides. It complements the combinational fp32 reciprocal path: it produces a correctly rounded quotient, round-to-nearest-even, in place of a y0-seeded 1/x estimate. It sits in the fp32 arithmetic library beside the add, mul and recip blocks and is intended for low-area datapaths that tolerate a 28-cycle latency.

## Interface
Parameters:
- QNAN, 32'h7FC00001, canonical quiet-NaN result pattern.
- ITER, 26, number of quotient bits produced: 1 integer bit plus 25 fraction bits. This is fixed; other values are unsupported.

Ports:
- clk  in  1  single clock. All state is updated on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block is idle and accepts operands.
- a  in  32  dividend, IEEE-754 binary32.
- b  in  32  divisor, IEEE-754 binary32.
- out_valid  out  1  result valid. It is held until accepted.
- out_ready  in  1  downstream accepts the result.
- result  out  32  quotient.
- flags  out  5  {NV, DZ, OF, UF, NX}: invalid, divide-by-zero, overflow, underflow, inexact.

## Operation
- FSM states: IDLE, CALC, NORM, DONE.
- in_ready = (state == IDLE).
- Accept occurs when in_valid && in_ready. On accept, operands are unpacked and registered.
- Denormal inputs are flushed to zero (FTZ) before classification.
- Sign of the result = sa ^ sb.

Special cases are decided on accept and go IDLE→DONE directly:
- Either operand NaN → QNAN, no flags set.
- 0/0 or inf/inf → QNAN, NV set.
- finite nonzero / 0 → signed inf, DZ set.
- inf / finite → signed inf.
- finite / inf → signed zero.
- 0 / nonzero finite → signed zero.

Normal path:
- ma and mb are 24 bits, including the hidden 1. Remainder r starts at ma.
- Each CALC cycle, restoring division: if r >= mb then q bit = 1 and r = r - mb. Then r = r << 1. r is 26 bits wide.
- After ITER cycles, sticky = (r != 0). FSM goes to NORM.
- NORM when q[25] = 1: mant = q[24:2], guard = q[1], st = q[0] | sticky, exp = ea - eb + 127.
- NORM when q[25] = 0: mant = q[23:1], guard = q[0], st = sticky, exp = ea - eb + 126.
- Exponent arithmetic is 10-bit signed.
- Rounding is RNE: increment if guard & (st | mant[0]). On mantissa carry-out, mant = 0 and exp += 1.
- NX = guard | st.
- After rounding, exp >= 255 → signed inf with OF and NX set. exp <= 0 → signed zero with UF and NX set; no denormal outputs are produced.
- DONE: out_valid = 1. result and flags are held stable until out_valid && out_ready, then the FSM returns to IDLE.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, result = 0, flags = 0.
- Cycle 0 is the accept edge.
- Normal path: CALC during cycles 1–26, NORM in cycle 27, out_valid from cycle 28.
- Special-case path: out_valid from cycle 1.
- No overlap: in_ready stays 0 from the accept edge until the cycle after the output handshake. in_valid while busy is ignored, with no side effects.
- Throughput is one operation per at least 29 cycles when out_ready is held at 1.
- out_ready asserted while out_valid = 0 has no effect.
- result and flags may change only on the NORM→DONE or IDLE→DONE transitions.
- Reset asserted mid-operation: the block returns to reset values immediately, without waiting for a clock edge, and the partial result is discarded.

## Structure
- Shared package fp32_pkg holds:
  - the QNAN pattern;
  - EXP_BIAS = 127;
  - field widths (EXP_W = 8, MANT_W = 23);
  - the special-class encodings (zero, inf, nan, normal);
  - the FSM state enum.
- One sub-module, fp32_mant_div. It contains the iterative restoring mantissa divider: start, ma, mb in; q[25:0], sticky, done out; a 5-bit iteration counter.
- The top level contains unpack/classify, the FSM, normalize/round, and the output registers.

## Test plan
1. 1.0/3.0 (a = 3F800000, b = 40400000) → result 3EAAAAAB, flags NX = 1 only, out_valid exactly at cycle 28.
2. 6.0/2.0 (a = 40C00000, b = 40000000) → result 40400000, flags 0. The normalization branch with q[25] = 1 is exercised.
3. Special cases, each with out_valid at cycle 1:
   - 3F800000/00000000 → 7F800000, DZ set.
   - 00000000/00000000 → 7FC00001, NV set.
   - FF800000/40000000 → FF800000, no flags.
4. Range limits:
   - 7F7FFFFF/3F000000 → 7F800000, OF and NX set.
   - 00800000/40000000 → 00000000, UF and NX set.
5. Backpressure: hold out_ready = 0 for 10 cycles after out_valid. result and flags are stable and in_ready = 0. A second in_valid pulse during this window is ignored. The next accept occurs only after the handshake.
6. Reset: assert rst_n = 0 at cycle 10 of a CALC. out_valid = 0 and in_ready = 1 immediately. After release, 6.0/2.0 returns 40400000.
